// File: rtl/ppu_seq_ctrl.sv
// PPU sequencing controller: streams a parameter block into the PPU one byte
// per handshake, then forwards PPU pixels to the VGA path until a reload.
module ppu_seq_ctrl #(
  parameter int         NPARAM   = 10,
  parameter logic [2:0] MODE_RST = 3'd5,
  parameter int         TIMEOUT  = 255
) (
  input  logic       clk_pix,
  input  logic       sim_rst,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       start,
  input  logic       frame_start,
  output logic       ppu_sync,
  output logic       ppu_stb_i,
  output logic [7:0] ppu_data_i,
  output logic [2:0] ppu_mode,
  input  logic       ppu_ack_i,
  input  logic [7:0] ppu_data_o,
  input  logic       ppu_stb_o,
  output logic       ppu_ack_o,
  output logic [7:0] pix_data,
  output logic       busy,
  output logic       err
);

  localparam int IW = $clog2(NPARAM);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(NPARAM - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT - 1);
  localparam logic [3:0]    NPARAM_A  = 4'(NPARAM);
  localparam logic [3:0]    MODE_ADDR = 4'd15;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_PEND = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [IW-1:0] idx;
  logic [WW-1:0] wcnt;
  logic          dirty;
  logic [7:0]    param [NPARAM];
  logic [2:0]    mode_sh;

  logic addr_param, addr_mode, cfg_hit;
  logic last_byte, wait_done, tracking, pix_live, enter_load;

  // The two colour-depth LSBs the VGA format drops.
  logic unused_pix_lsbs;
  assign unused_pix_lsbs = ^ppu_data_o[1:0];

  assign addr_param = (cfg_addr < NPARAM_A);
  assign addr_mode  = (cfg_addr == MODE_ADDR);
  assign cfg_hit    = cfg_we && (addr_param || addr_mode);
  assign last_byte  = (idx == LAST_IDX);
  assign wait_done  = (wcnt == WAIT_MAX);
  assign tracking   = (state == S_LOAD) || (state == S_RUN) || (state == S_PEND);
  assign pix_live   = (state == S_RUN) || (state == S_PEND);
  assign enter_load = (state_nxt == S_LOAD) && (state != S_LOAD);

  // NOTE: state_nxt is assigned before the case so every path drives it;
  // a missing default in combinational logic would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (ppu_ack_i) begin
          if (last_byte) state_nxt = S_RUN;
        end else if (wait_done) begin
          state_nxt = S_ERR;
        end
      end
      S_RUN: begin
        if (start && frame_start)            state_nxt = S_LOAD;
        else if (dirty || cfg_hit || start)  state_nxt = S_PEND;
      end
      S_PEND: if (frame_start) state_nxt = S_LOAD;
      S_ERR:  if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_pix or posedge sim_rst) begin
    if (sim_rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      wcnt       <= '0;
      dirty      <= 1'b0;
      mode_sh    <= MODE_RST;
      ppu_mode   <= MODE_RST;
      ppu_sync   <= 1'b0;
      ppu_stb_i  <= 1'b0;
      ppu_data_i <= '0;
      ppu_ack_o  <= 1'b0;
      pix_data   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
      // NOTE: the parameter file is reset because a load issued straight
      // out of reset must send zeros, not power-up garbage.
      for (int i = 0; i < NPARAM; i++) param[i] <= '0;
    end else begin
      state <= state_nxt;

      if (cfg_we && addr_param) param[cfg_addr[IW-1:0]] <= cfg_wdata;
      if (cfg_we && addr_mode)  mode_sh <= cfg_wdata[2:0];

      if (enter_load)                         dirty <= 1'b0;
      else if (tracking && (cfg_hit || start)) dirty <= 1'b1;

      if (enter_load) begin
        idx        <= '0;
        wcnt       <= '0;
        ppu_mode   <= mode_sh;
        ppu_sync   <= 1'b1;
        ppu_stb_i  <= 1'b1;
        ppu_data_i <= param[0];
        ppu_ack_o  <= 1'b0;
        busy       <= 1'b1;
        err        <= 1'b0;
      end else if (state == S_LOAD) begin
        if (ppu_ack_i) begin
          wcnt <= '0;
          if (last_byte) begin
            idx        <= '0;
            ppu_sync   <= 1'b0;
            ppu_stb_i  <= 1'b0;
            ppu_data_i <= '0;
            busy       <= 1'b0;
            ppu_ack_o  <= 1'b1;
          end else begin
            idx        <= idx + 1'b1;
            ppu_data_i <= param[idx + 1'b1];
          end
        end else if (wait_done) begin
          wcnt       <= '0;
          ppu_sync   <= 1'b0;
          ppu_stb_i  <= 1'b0;
          ppu_data_i <= '0;
          busy       <= 1'b0;
          err        <= 1'b1;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end

      // Pixels are accepted in RUN and PEND alike; ERR blanks the output.
      if (pix_live && ppu_stb_o)
        pix_data <= {ppu_data_o[7:2], 2'b00};
      else if ((state == S_LOAD) && (state_nxt == S_ERR))
        pix_data <= '0;
    end
  end

endmodule

// File: tb/tb_ppu_seq_ctrl.sv
// Self-checking bench for ppu_seq_ctrl: a monitor scores PPU byte transfers and
// pixel outputs against queues filled by the stimulus from a parameter-file model.
module tb_ppu_seq_ctrl;

  localparam int         NP = 10;
  localparam int         TO = 255;
  localparam logic [2:0] MR = 3'd5;

  logic       clk_pix = 1'b0;
  logic       sim_rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic       start = 1'b0;
  logic       frame_start = 1'b0;
  logic       ppu_sync, ppu_stb_i;
  logic [7:0] ppu_data_i;
  logic [2:0] ppu_mode;
  logic       ppu_ack_i = 1'b0;
  logic [7:0] ppu_data_o = '0;
  logic       ppu_stb_o = 1'b0;
  logic       ppu_ack_o;
  logic [7:0] pix_data;
  logic       busy, err;

  ppu_seq_ctrl #(.NPARAM(NP), .MODE_RST(MR), .TIMEOUT(TO)) dut (
    .clk_pix(clk_pix), .sim_rst(sim_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .frame_start(frame_start),
    .ppu_sync(ppu_sync), .ppu_stb_i(ppu_stb_i), .ppu_data_i(ppu_data_i),
    .ppu_mode(ppu_mode), .ppu_ack_i(ppu_ack_i), .ppu_data_o(ppu_data_o),
    .ppu_stb_o(ppu_stb_o), .ppu_ack_o(ppu_ack_o), .pix_data(pix_data),
    .busy(busy), .err(err)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mparam [NP];
  logic [2:0]  mmode = MR;
  logic [2:0]  applied_mode = MR;
  logic [10:0] exp_byte_q [$];
  logic [7:0]  exp_pix_q [$];
  int          sync_cnt;
  logic        ack_o_early;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Monitor: scores every handshake the DUT presents.
  logic [10:0] mon_e;
  logic        pix_due = 1'b0;
  always @(negedge clk_pix) begin
    if (sim_rst) begin
      pix_due = 1'b0;
    end else begin
      if (ppu_stb_i && ppu_ack_i) begin
        check("byte_q_avail", 32'(exp_byte_q.size() != 0), 32'd1);
        if (exp_byte_q.size() != 0) begin
          mon_e = exp_byte_q.pop_front();
          check("byte_data", ppu_data_i, mon_e[7:0]);
          check("byte_mode", ppu_mode, mon_e[10:8]);
        end
      end
      if (pix_due) begin
        check("pix_q_avail", 32'(exp_pix_q.size() != 0), 32'd1);
        if (exp_pix_q.size() != 0) check("pix_data", pix_data, exp_pix_q.pop_front());
      end
      pix_due = ppu_stb_o && ppu_ack_o;
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (int'(a) < NP) mparam[a] = d;
    else if (a == 4'd15) mmode = d[2:0];
  endtask

  task automatic begin_load(input bit st, input bit fs, input bit push);
    applied_mode = mmode;
    if (push) for (int i = 0; i < NP; i++) exp_byte_q.push_back({mmode, mparam[i]});
    start = st; frame_start = fs;
    tick();
    start = 1'b0; frame_start = 1'b0;
    check("load_stb", ppu_stb_i, 1);
    check("load_busy", busy, 1);
    check("load_err_clr", err, 0);
    check("load_mode", ppu_mode, applied_mode);
  endtask

  task automatic feed(input int n, input int stall_b, input int stall_len, input bit rnd,
                      input int wr_b, input logic [7:0] wr_v);
    int gap;
    sync_cnt = 0; ack_o_early = 1'b0;
    for (int b = 0; b < n; b++) begin
      gap = (b == stall_b) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      ppu_ack_i = 1'b0;
      for (int g = 0; g < gap; g++) begin
        sync_cnt += int'(ppu_sync); ack_o_early |= ppu_ack_o;
        tick();
        if (b == stall_b) begin
          check("stall_hold", ppu_data_i, mparam[b]);
          check("stall_stb", ppu_stb_i, 1);
        end
      end
      ppu_ack_i = 1'b1;
      if (b == wr_b) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = wr_v; end
      sync_cnt += int'(ppu_sync); ack_o_early |= ppu_ack_o;
      tick();
      if (b == wr_b) begin cfg_we = 1'b0; mparam[0] = wr_v; end
    end
    ppu_ack_i = 1'b0;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_ack_o"}, ppu_ack_o, 1);
    check({tag, "_sync"}, ppu_sync, 0);
    check({tag, "_stb"}, ppu_stb_i, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] d;
  bit         s;
  logic [7:0] last_pix;
  logic [7:0] scen [NP] = '{8'd42, 8'd123, 8'd87, 8'd255, 8'd0, 8'd198, 8'd76, 8'd34, 8'd210, 8'hB6};

  initial begin
    for (int i = 0; i < NP; i++) mparam[i] = '0;
    tick(); tick();
    sim_rst = 1'b0;
    check("rst_stb", ppu_stb_i, 0);
    check("rst_sync", ppu_sync, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_mode", ppu_mode, MR);
    check("rst_pix", pix_data, 0);
    check("rst_ack_o", ppu_ack_o, 0);

    // Reference load: ack every cycle.
    for (int i = 0; i < NP; i++) cfg_write(4'(i), scen[i]);
    begin_load(1, 0, 1);
    feed(NP, -1, 0, 0, -1, 8'd0);
    check("sync_cycles", 32'(sync_cnt), 32'(NP));
    check("run_not_early", ack_o_early, 0);
    check_run("run1");

    // Pixel path.
    ppu_stb_o = 1'b1; ppu_data_o = 8'hFF; exp_pix_q.push_back(8'hFC);
    tick();
    ppu_stb_o = 1'b0; ppu_data_o = 8'h13;
    check("pix_ff", pix_data, 8'hFC);
    last_pix = 8'hFC;
    tick(); tick();
    check("pix_hold", pix_data, last_pix);
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom); s = 1'($urandom_range(0, 1));
      ppu_stb_o = s; ppu_data_o = d;
      if (s) begin last_pix = {d[7:2], 2'b00}; exp_pix_q.push_back(last_pix); end
      tick();
    end
    ppu_stb_o = 1'b0; ppu_data_o = 8'($urandom);
    tick(); tick();
    check("pix_hold_rand", pix_data, last_pix);

    // Ignored address, stray ack and lone frame_start must not reload.
    cfg_write(4'd12, 8'h5A);
    ppu_ack_i = 1'b1; tick(); tick(); ppu_ack_i = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    check("ign_no_reload", ppu_stb_i, 0);
    check("ign_ack_o", ppu_ack_o, 1);

    // start+frame_start together: straight to LOAD; byte 4 stalls 3 cycles.
    begin_load(1, 1, 1);
    feed(NP, 4, 3, 0, -1, 8'd0);
    check_run("run2");

    // Mode write in RUN waits for a frame boundary.
    cfg_write(4'd15, 8'd4);
    tick(); tick(); tick();
    check("pend_mode_held", ppu_mode, applied_mode);
    check("pend_no_load", ppu_stb_i, 0);
    check("pend_ack_o", ppu_ack_o, 1);
    ppu_stb_o = 1'b1; ppu_data_o = 8'h6E; exp_pix_q.push_back(8'h6C);
    tick(); ppu_stb_o = 1'b0;
    begin_load(0, 1, 1);
    check("pend_mode_new", ppu_mode, 3'd4);
    feed(NP, -1, 0, 1, 3, 8'($urandom));
    check_run("run3");

    // Write during LOAD marked the block dirty: reload only on frame_start.
    tick(); tick(); tick(); tick();
    check("dirty_wait", ppu_stb_i, 0);
    begin_load(0, 1, 1);
    feed(NP, -1, 0, 1, -1, 8'd0);
    check_run("run4");

    // Timeout with no ack.
    begin_load(1, 1, 0);
    repeat (TO - 1) tick();
    check("to_before", err, 0);
    check("to_before_stb", ppu_stb_i, 1);
    tick();
    check("to_err", err, 1);
    check("to_stb", ppu_stb_i, 0);
    check("to_sync", ppu_sync, 0);
    check("to_ack_o", ppu_ack_o, 0);
    check("to_pix", pix_data, 0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick();
    check("err_fs_ign", err, 1);
    check("err_fs_stb", ppu_stb_i, 0);
    begin_load(1, 0, 1);
    feed(NP, -1, 0, 1, -1, 8'd0);
    check_run("run5");

    // Asynchronous reset mid-LOAD at idx 5.
    begin_load(1, 1, 1);
    feed(5, -1, 0, 1, -1, 8'd0);
    exp_byte_q.delete();
    #2 sim_rst = 1'b1;
    #1;
    check("arst_stb", ppu_stb_i, 0);
    check("arst_sync", ppu_sync, 0);
    check("arst_busy", busy, 0);
    check("arst_data", ppu_data_i, 0);
    check("arst_mode", ppu_mode, MR);
    check("arst_ack_o", ppu_ack_o, 0);
    check("arst_pix", pix_data, 0);
    for (int i = 0; i < NP; i++) mparam[i] = '0;
    mmode = MR;
    tick();
    sim_rst = 1'b0;
    begin_load(1, 0, 1);
    feed(NP, -1, 0, 1, -1, 8'd0);
    check_run("run6");

    // Fresh random block from IDLE after reset.
    sim_rst = 1'b1; tick(); sim_rst = 1'b0;
    for (int i = 0; i < NP; i++) cfg_write(4'(i), 8'($urandom));
    cfg_write(4'd15, 8'($urandom));
    begin_load(1, 0, 1);
    feed(NP, -1, 0, 1, -1, 8'd0);
    check_run("run7");

    tick(); tick();
    check("byte_q_empty", 32'(exp_byte_q.size()), 32'd0);
    check("pix_q_empty", 32'(exp_pix_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_seq_ctrl.md
PPU_SEQ_CTRL -- requirements
Module: ppu_seq_ctrl

Interface
REQ-001 SHALL have parameter NPARAM, default 10: number of parameter bytes sent to the PPU per load (2..15).
REQ-002 SHALL have parameter MODE_RST, default 3'd5: ppu_mode value after reset.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for ppu_ack_i per byte.
REQ-004 clk_pix  in  1  pixel clock; all logic on posedge.
REQ-005 sim_rst  in  1  reset, asynchronous, active-high.
REQ-006 cfg_we  in  1  config write strobe, one write per cycle.
REQ-007 cfg_addr  in  4  0..NPARAM-1 selects a parameter byte; 15 selects the mode register; other values are ignored.
REQ-008 cfg_wdata  in  8  config write data; the mode register takes bits [2:0].
REQ-009 start  in  1  single-cycle pulse requesting a parameter load.
REQ-010 frame_start  in  1  single-cycle pulse, asserted when sx==0 and sy==0 with de active.
REQ-011 ppu_sync, ppu_stb_i  out  1 each  PPU load-phase sync and data strobe.
REQ-012 ppu_data_i  out  8 / ppu_mode  out  3  parameter byte and mode sent to the PPU.
REQ-013 ppu_ack_i  in  1  PPU accepts the current ppu_data_i.
REQ-014 ppu_data_o  in  8 / ppu_stb_o  in  1  PPU pixel output and its valid flag.
REQ-015 ppu_ack_o  out  1  controller accepts PPU output.
REQ-016 pix_data  out  8  pixel byte to the VGA driver, formatted {RRGGBB,2'b00}.
REQ-017 busy, err  out  1 each  busy: load in progress; err: sticky timeout flag.

Function
REQ-018 SHALL hold NPARAM x 8-bit parameter registers and a 3-bit mode shadow register; cfg_we updates these on the clock edge in any state.
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, PEND, ERR, all registered; outputs SHALL be registered.
REQ-020 IDLE: start -> LOAD on the next cycle, with idx=0 and ppu_mode loaded from the mode shadow.
REQ-021 LOAD: ppu_sync=1, ppu_stb_i=1, ppu_data_i=param[idx], busy=1.
REQ-022 LOAD byte transfer: a byte transfers on any cycle with ppu_stb_i=1 and ppu_ack_i=1; idx then increments and the wait counter clears.
REQ-023 LOAD completion: after the transfer with idx==NPARAM-1 -> RUN next cycle; idx returns to 0; ppu_sync, ppu_stb_i and busy go to 0 in that cycle.
REQ-024 LOAD timeout: the wait counter increments each cycle without ack; reaching TIMEOUT -> ERR, err=1, ppu_stb_i=0, ppu_sync=0.
REQ-025 RUN: ppu_ack_o=1; when ppu_stb_o=1, pix_data <= {ppu_data_o[7:2],2'b00} with 1-cycle latency; otherwise pix_data holds its value.
REQ-026 RUN dirty flag: a cfg_we to a valid address, or a start pulse, sets the dirty flag; RUN with dirty=1 -> PEND.
REQ-027 PEND: keeps RUN output behaviour; on frame_start -> LOAD (dirty cleared, mode shadow applied), so that reloads occur only at frame boundaries.
REQ-028 RUN simultaneous events: start and frame_start in the same RUN cycle -> LOAD directly, with no PEND cycle.
REQ-029 LOAD writes: cfg_we during LOAD does not alter the byte in flight, since ppu_data_i is registered at idx advance; the write sets dirty, so a reload follows at the next frame_start after RUN.
REQ-030 ERR: ppu_ack_o=0, pix_data=0; start clears err and goes to LOAD; frame_start is ignored.
REQ-031 Ignored addresses: writes to addresses NPARAM..14 SHALL have no effect and SHALL NOT set dirty.
REQ-032 ppu_ack_i outside LOAD SHALL be ignored.

Reset
REQ-033 On sim_rst: state=IDLE, idx=0, wait counter=0, dirty=0, params=0, mode shadow=MODE_RST, ppu_mode=MODE_RST, all other outputs 0.
REQ-034 Reset mid-LOAD: asserting sim_rst during LOAD SHALL abort immediately; no ppu_stb_i is held after the asynchronous assertion.

Verification
REQ-035 Scenario: write params 42,123,87,255,0,198,76,34,210,0xB6, start, ack every cycle -> 10 bytes in order, RUN entered 11 cycles after start, ppu_sync high for exactly 10 cycles.
REQ-036 Scenario: ppu_ack_i low for 3 cycles on byte 4 -> ppu_data_i holds 0 stable for those cycles, and transfer order is unchanged.
REQ-037 Scenario: in RUN, ppu_stb_o=1 with ppu_data_o=0xFF -> pix_data=0xFC one cycle later; with ppu_stb_o=0, pix_data is held.
REQ-038 Scenario: in RUN, write addr 15 = 3'd4 -> PEND; ppu_mode stays 5 until frame_start, then becomes 4 and LOAD restarts from idx 0.
REQ-039 Scenario: no ack with TIMEOUT=255 -> err=1 exactly 255 cycles after LOAD entry; a following start clears err and reloads.
REQ-040 Scenario: sim_rst asserted mid-LOAD at idx=5 -> all outputs 0 and ppu_mode=5 immediately; the next start sends from idx 0.
